// File: rtl/decode_pkg.sv
// Shared decode definitions: instruction field positions, register address
// width, the immediate-form selector bit and the decoded bundle handed to
// the execute stage. Also imported by the execute-stage wrapper.
package decode_pkg;

  localparam int DATA_W = 32;
  localparam int AW     = 5;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 25;
  localparam int RD_HI  = 24;
  localparam int RD_LO  = 20;
  localparam int RS_HI  = 19;
  localparam int RS_LO  = 15;
  localparam int RT_HI  = 14;
  localparam int RT_LO  = 10;
  localparam int SH_HI  = 9;
  localparam int SH_LO  = 5;
  localparam int FS_HI  = 3;
  localparam int FS_LO  = 0;
  localparam int IMM_W  = 15;
  localparam int IMM_BIT = 6;   // opcode[6] selects the immediate form

  typedef struct packed {
    logic [6:0]        opcode;
    logic [3:0]        fs;
    logic [4:0]        sh;
    logic [AW-1:0]     rd;
    logic [DATA_W-1:0] busA;
    logic [DATA_W-1:0] busB;
  } decode_bundle_t;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// Register file: two asynchronous read ports, one synchronous write port.
// r0 reads as zero and ignores writes; every register clears on reset.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   ra_addr / ra_data   read port A
//   rb_addr / rb_data   read port B
//   we, wa, wd          write enable, address, data
module reg_file_2r1w #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  assign ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];

endmodule

// File: rtl/inst_decode.sv
// Decode / register-read stage. Splits the instruction, reads operands
// (with writeback bypass), tracks outstanding destinations in a scoreboard
// and registers the decoded bundle for the execute stage.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid, in_inst, in_ready   instruction handshake from fetch
//   out_valid, out_ready          bundle handshake to execute
//   busA, busB, opcode, fs, sh    decoded operands and control
//   out_rd                        destination register for writeback
//   wb_en, wb_addr, wb_data       writeback port
module inst_decode
  import decode_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [31:0]   in_inst,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] busA,
  output logic [DW-1:0] busB,
  output logic [6:0]    opcode,
  output logic [3:0]    fs,
  output logic [4:0]    sh,
  output logic [4:0]    out_rd,
  input  logic          wb_en,
  input  logic [4:0]    wb_addr,
  input  logic [DW-1:0] wb_data
);

  logic [6:0]    f_opc;
  logic [AW-1:0] f_rd, f_rs, f_rt;
  logic [4:0]    f_sh;
  logic [3:0]    f_fs;
  logic          is_imm;
  logic          unused_inst4;

  assign f_opc  = in_inst[OPC_HI:OPC_LO];
  assign f_rd   = in_inst[RD_HI:RD_LO];
  assign f_rs   = in_inst[RS_HI:RS_LO];
  assign f_rt   = in_inst[RT_HI:RT_LO];
  assign f_sh   = in_inst[SH_HI:SH_LO];
  assign f_fs   = in_inst[FS_HI:FS_LO];
  assign is_imm = f_opc[IMM_BIT];
  assign unused_inst4 = in_inst[4];

  logic [DW-1:0] rf_a, rf_b;

  reg_file_2r1w #(.DW(DW), .NREG(NREG), .AW(AW)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (f_rs),
    .ra_data (rf_a),
    .rb_addr (f_rt),
    .rb_data (rf_b),
    .we      (wb_en),
    .wa      (wb_addr),
    .wd      (wb_data)
  );

  logic [NREG-1:0] pending, pending_d;
  logic wb_hit_rs, wb_hit_rt, wb_hit_rd;
  logic hazard, accept;
  logic [DW-1:0] opa, opb;

  assign wb_hit_rs = wb_en && (wb_addr == f_rs);
  assign wb_hit_rt = wb_en && (wb_addr == f_rt);
  assign wb_hit_rd = wb_en && (wb_addr == f_rd);

  // A writeback landing this cycle resolves the hazard on its register, so
  // the dependent instruction can be accepted with the bypassed value.
  // Computed without in_valid so that in_ready never depends on in_valid.
  assign hazard = (pending[f_rs] && !wb_hit_rs)
               || (!is_imm && pending[f_rt] && !wb_hit_rt)
               || (pending[f_rd] && !wb_hit_rd);

  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign opa = ((f_rs != '0) && wb_hit_rs) ? wb_data : rf_a;
  assign opb = is_imm ? sext_imm(in_inst[IMM_W-1:0])
             : (((f_rt != '0) && wb_hit_rt) ? wb_data : rf_b);

  // Clear first, then set, so a same-cycle accept to the register being
  // written back leaves the new write outstanding.
  always_comb begin
    pending_d = pending;
    if (wb_en) pending_d[wb_addr] = 1'b0;
    if (accept && (f_rd != '0)) pending_d[f_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  decode_bundle_t bundle_d, bundle_q;

  always_comb begin
    bundle_d        = '0;
    bundle_d.opcode = f_opc;
    bundle_d.fs     = f_fs;
    bundle_d.sh     = f_sh;
    bundle_d.rd     = f_rd;
    bundle_d.busA   = opa;
    bundle_d.busB   = opb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      bundle_q  <= '0;
      pending   <= '0;
    end else begin
      pending <= pending_d;
      if (accept) begin
        bundle_q  <= bundle_d;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busA   = bundle_q.busA;
  assign busB   = bundle_q.busB;
  assign opcode = bundle_q.opcode;
  assign fs     = bundle_q.fs;
  assign sh     = bundle_q.sh;
  assign out_rd = bundle_q.rd;

endmodule
